// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the five-button conditioner.
package button_conditioner_pkg;

  localparam int unsigned NUM_BUTTONS = 5;

  // Button bit positions within push/level/pulse
  localparam int unsigned PUSH_U = 0;
  localparam int unsigned PUSH_D = 1;
  localparam int unsigned PUSH_L = 2;
  localparam int unsigned PUSH_R = 3;
  localparam int unsigned PUSH_M = 4;

  // Default timing, in clock cycles
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20000;
  localparam int unsigned DEF_REPEAT_DELAY    = 500000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 100000;
  localparam logic [NUM_BUTTONS-1:0] DEF_REPEAT_MASK = 5'b00011;

  // Per-button auto-repeat state
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Larger of two parameters, used to size the shared repeat counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchronizer, debounce counter and auto-repeat FSM.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  output logic level,
  output logic pulse,
  output logic pulse_next_c
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  logic             sync_meta;
  logic             sync;
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  rpt_state_e       state;

  logic mismatch;
  logic toggle;
  logic press;
  logic release_ev;
  logic rpt_due;

  // Event decode: debounce completion and repeat deadlines for this cycle
  always_comb begin
    mismatch     = 1'b0;
    toggle       = 1'b0;
    press        = 1'b0;
    release_ev   = 1'b0;
    rpt_due      = 1'b0;
    pulse_next_c = 1'b0;

    mismatch   = (sync != level);
    toggle     = mismatch && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    press      = toggle && !level;
    release_ev = toggle && level;
    rpt_due    = ((state == RPT_DELAY)  && (rpt_cnt == RPT_W'(REPEAT_DELAY - 1))) ||
                 ((state == RPT_REPEAT) && (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1)));
    // A release landing on a repeat deadline wins and swallows that strobe
    pulse_next_c = press || (rpt_due && !release_ev);
  end

  // Synchronizer, debounce counter, registered outputs and repeat FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      db_cnt    <= '0;
      level     <= 1'b0;
      pulse     <= 1'b0;
      rpt_cnt   <= '0;
      state     <= RPT_IDLE;
    end else begin
      sync_meta <= push;
      sync      <= sync_meta;

      if (!mismatch || toggle) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end

      level <= level ^ toggle;
      pulse <= pulse_next_c;

      case (state)
        RPT_IDLE: begin
          rpt_cnt <= '0;
          if (press && REPEAT_EN) begin
            state <= RPT_DELAY;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (release_ev) begin
            state   <= RPT_IDLE;
            rpt_cnt <= '0;
          end else if (rpt_due) begin
            state   <= RPT_REPEAT;
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
        default: begin
          state   <= RPT_IDLE;
          rpt_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five independent button channels plus a registered any-press strobe.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] push,
  output logic [NUM_BUTTONS-1:0] level,
  output logic [NUM_BUTTONS-1:0] pulse,
  output logic                   any_pulse
);

  logic [NUM_BUTTONS-1:0] pulse_next;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .push        (push[i]),
      .level       (level[i]),
      .pulse       (pulse[i]),
      .pulse_next_c(pulse_next[i])
    );
  end

  // any_pulse registered from the channels' next-pulse terms so it aligns with pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      any_pulse <= 1'b0;
    end else begin
      any_pulse <= |pulse_next;
    end
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required before the debounced level changes (minimum 2).
REQ-002 Parameter REPEAT_DELAY, default 500000: cycles from the press pulse to the first auto-repeat pulse (minimum 2).
REQ-003 Parameter REPEAT_PERIOD, default 100000: cycles between successive auto-repeat pulses (minimum 2).
REQ-004 Parameter REPEAT_MASK, default 5'b00011: per-button auto-repeat enable; by default only up and down repeat.
REQ-005 clk  input  1: the single clock; all state changes on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 push  input  5: raw, asynchronous, bouncing buttons; bit0 up, bit1 down, bit2 left, bit3 right, bit4 middle.
REQ-008 level  output  5: debounced button state, 1 while held.
REQ-009 pulse  output  5: one-cycle strobe per press event, including auto-repeat strobes.
REQ-010 any_pulse  output  1: OR of pulse.

Function
REQ-011 Each push bit SHALL pass through a 2-flop synchronizer; only the synchronizer output (sync) is used downstream.
REQ-012 Per button, a debounce counter SHALL:
- clear whenever sync equals level;
- increment whenever sync differs from level.
REQ-013 level[i] SHALL toggle on the DEBOUNCE_CYCLES-th consecutive edge at which sync[i] differs from level[i], and the counter SHALL clear on that same edge.
- Latency from the raw input first sampled changed: DEBOUNCE_CYCLES+2 edges.
REQ-014 A mismatch run shorter than DEBOUNCE_CYCLES SHALL leave level unchanged and produce no pulse; this is the glitch and bounce case.
REQ-015 pulse[i] SHALL be high for exactly the cycle in which level[i] is first high (press pulse).
- Releases produce no pulse.
REQ-016 Per-button repeat state machine:
- States: IDLE, DELAY, REPEAT.
- IDLE->DELAY on the press pulse, only if REPEAT_MASK[i]=1.
- DELAY->REPEAT on the cycle the REPEAT_DELAY repeat pulse fires.
- DELAY or REPEAT -> IDLE when level[i] falls.
REQ-017 For a press pulse in cycle t with REPEAT_MASK[i]=1, repeat pulses SHALL occur in cycles t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_PERIOD, t+REPEAT_DELAY+2*REPEAT_PERIOD, and so on, while level[i] stays high.
REQ-018 A release that debounces in the same cycle a repeat pulse is due SHALL suppress that pulse; the release takes priority.
REQ-019 Buttons SHALL be fully independent; simultaneous presses produce simultaneous pulses in the same cycle.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter plus 1, and counters SHALL never wrap while a button is held indefinitely; the repeat counter reloads each period.
REQ-021 All outputs SHALL be registered; there is no combinational path from push to any output.

Reset
REQ-022 While reset=1 at a clock edge, the following SHALL clear to 0 on that edge: synchronizers, level, pulse, any_pulse, all counters. All FSMs SHALL return to IDLE on that edge.
REQ-023 A button held across reset deassertion SHALL be treated as a new press: exactly one press pulse, DEBOUNCE_CYCLES+2 edges after reset falls.
REQ-024 Reset asserted mid-repeat SHALL abort the repeat with no further pulses.

Structure
REQ-025 Shared package contents:
- Button index constants: PUSH_U=0, PUSH_D=1, PUSH_L=2, PUSH_R=3, PUSH_M=4.
- Default timing constants.
- Repeat FSM state encoding.
REQ-026 A sub-module button_channel, holding one bit's synchronizer, debounce and repeat FSM, SHALL be instantiated 5 times; the top level contains only the instances, REPEAT_MASK routing and the any_pulse OR.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-027 Clean press: push[0] rises at edge 0 and is held 8 cycles -> level[0] rises and pulse[0] is high for one cycle at edge 6; releasing gives level[0] falling 6 edges later with no pulse.
REQ-028 Bounce: push[2] toggles 1,0,1,0,1 on alternate cycles, then stays 1 -> exactly one pulse[2], 6 edges after the final rise; no pulse on the 1-cycle glitches.
REQ-029 Auto-repeat: push[1] held 40 cycles with press pulse at t -> pulses at t, t+10, t+13, t+16, t+19, ..., stopping once level[1] falls.
REQ-030 No repeat on masked button: push[4] held 40 cycles -> exactly one pulse[4].
REQ-031 Simultaneous presses: push=5'b00011 rising together -> pulse=5'b00011 in one cycle and any_pulse=1 in that cycle.
REQ-032 Reset: reset pulsed during repeat of push[0], button still held -> no pulses while reset is high, then exactly one press pulse 6 edges after reset falls.
